// File: rtl/fetch_buffer.sv
// Instruction fetch stage: req/ack fetch from instruction memory into a
// small FIFO whose head feeds decode as opcode/operand/pc.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  input  logic                     mem_ack,
  input  logic [15:0]              mem_data,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [AW-1:0]            flush_pc,
  output logic                     inst_valid,
  output logic [6:0]               opcode,
  output logic [8:0]               operand,
  output logic [AW-1:0]            inst_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + 16;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  always_comb begin
    mem_req  = !reset && (count_q < FULL);
    push     = mem_req && mem_ack && !flush;
    pop      = (count_q != '0) && !stall && !flush;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      // redirect wins: queued and in-flight words are dropped
      pc_d     = flush_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {pc_q, mem_data};
        wr_ptr_d        = wr_ptr_q + PW'(1);
        pc_d            = pc_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign mem_addr   = pc_q;
  assign inst_valid = (count_q != '0);
  assign opcode     = head[15:9];
  assign operand    = head[8:0];
  assign inst_pc    = head[EW-1:16];
  assign count      = count_q;

endmodule
